// File: rtl/hba_pkg.sv
// hba_pkg: default HBA bus widths and the master engine state encoding.
// Shared by the master top and its timeout counter.
package hba_pkg;

    localparam int HBA_ADDR_W = 12;
    localparam int HBA_DBUS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } hba_master_state_t;

endpackage

// File: rtl/hba_timeout_cnt.sv
// hba_timeout_cnt: saturating cycle counter for the XFER abort window.
// Expired once TIMEOUT-1 enabled cycles have been counted since clear.
module hba_timeout_cnt
    import hba_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/hba_master.sv
// hba_master: single-transfer HBA bus master with request/grant arbitration
// and a per-transfer ack timeout. All bus outputs come straight from flops.
module hba_master
    import hba_pkg::*;
#(
    parameter int ADDR_WIDTH = HBA_ADDR_W,
    parameter int DBUS_WIDTH = HBA_DBUS_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rnw,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DBUS_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DBUS_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  hba_mrequest,
    input  logic                  hba_mgrant,
    output logic                  hba_select,
    output logic [ADDR_WIDTH-1:0] hba_abus,
    output logic                  hba_rnw,
    output logic [DBUS_WIDTH-1:0] hba_dbus,
    input  logic [DBUS_WIDTH-1:0] hba_dbus_slave,
    input  logic                  hba_xferack
);

    hba_master_state_t r_state;

    logic                  r_cmd_ready;
    logic                  r_rnw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DBUS_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic [DBUS_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_mrequest;
    logic                  r_select;
    logic [ADDR_WIDTH-1:0] r_abus;
    logic                  r_bus_rnw;
    logic [DBUS_WIDTH-1:0] r_dbus;

    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_expired;

    assign w_cnt_clear  = (r_state == ST_REQ) && hba_mgrant;
    assign w_cnt_enable = (r_state == ST_XFER) && !hba_xferack;

    hba_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .i_clk     (hba_clk),
        .i_rst_n   (hba_reset_n),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
            r_rnw       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mrequest  <= 1'b0;
            r_select    <= 1'b0;
            r_abus      <= '0;
            r_bus_rnw   <= 1'b0;
            r_dbus      <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_rnw       <= cmd_rnw;
                        r_addr      <= cmd_addr;
                        r_wdata     <= cmd_wdata;
                        r_cmd_ready <= 1'b0;
                        r_mrequest  <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (hba_mgrant) begin
                        r_mrequest <= 1'b0;
                        r_select   <= 1'b1;
                        r_abus     <= r_addr;
                        r_bus_rnw  <= r_rnw;
                        r_dbus     <= r_rnw ? '0 : r_wdata;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // ack wins over a timeout landing on the same edge
                    if (hba_xferack || w_expired) begin
                        if (hba_xferack && r_rnw) begin
                            r_rsp_rdata <= hba_dbus_slave;
                        end
                        r_rsp_err   <= !hba_xferack;
                        r_rsp_valid <= 1'b1;
                        r_select    <= 1'b0;
                        r_abus      <= '0;
                        r_bus_rnw   <= 1'b0;
                        r_dbus      <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_mrequest  <= 1'b0;
                    r_select    <= 1'b0;
                    r_abus      <= '0;
                    r_bus_rnw   <= 1'b0;
                    r_dbus      <= '0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_err      = r_rsp_err;
    assign hba_mrequest = r_mrequest;
    assign hba_select   = r_select;
    assign hba_abus     = r_abus;
    assign hba_rnw      = r_bus_rnw;
    assign hba_dbus     = r_dbus;

endmodule

// File: tb/tb_hba_master.sv
// tb_hba_master: table-driven transfers with a response/address scoreboard,
// plus spurious-handshake, mid-transfer reset and back-to-back sequences.
module tb_hba_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        hba_reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_rnw = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        hba_mrequest;
    logic        hba_mgrant = 1'b0;
    logic        hba_select;
    logic [11:0] hba_abus;
    logic        hba_rnw;
    logic [7:0]  hba_dbus;
    logic [7:0]  hba_dbus_slave = '0;
    logic        hba_xferack = 1'b0;

    typedef struct {
        logic        rnw;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          gdly;
        int          adly;
        logic [7:0]  sdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    vec_t        vecs[5];
    rsp_t        rsp_q[$];
    logic [11:0] addr_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_rsp_cyc = 0;
    logic prev_rv = 1'b0;
    logic prev_sel = 1'b0;
    logic auto_resp = 1'b0;

    hba_master #(
        .ADDR_WIDTH (12),
        .DBUS_WIDTH (8),
        .TIMEOUT    (TO)
    ) dut (
        .hba_clk        (clk),
        .hba_reset_n    (hba_reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rnw        (cmd_rnw),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .hba_mrequest   (hba_mrequest),
        .hba_mgrant     (hba_mgrant),
        .hba_select     (hba_select),
        .hba_abus       (hba_abus),
        .hba_rnw        (hba_rnw),
        .hba_dbus       (hba_dbus),
        .hba_dbus_slave (hba_dbus_slave),
        .hba_xferack    (hba_xferack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        if (auto_resp) begin
            #1;
            hba_mgrant  = hba_mrequest;
            hba_xferack = hba_select;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rsp_t r;
        logic [11:0] a;
        if (rsp_valid) begin
            chk("rsp_pulse", {31'd0, prev_rv}, 0);
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, rsp_valid}, 0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, r.rdata});
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
            end
            last_rsp_cyc = cyc;
        end
        if (hba_select && !prev_sel) begin
            if (addr_q.size() == 0) begin
                chk("sel_unexpected", {31'd0, hba_select}, 0);
            end else begin
                a = addr_q.pop_front();
                chk("sel_addr", {20'd0, hba_abus}, {20'd0, a});
            end
        end
        if (!hba_select) begin
            chk("bus_idle", {11'd0, hba_abus, hba_rnw, hba_dbus}, 0);
        end
        prev_rv  = rsp_valid;
        prev_sel = hba_select;
    end

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_wait", {31'd0, cmd_ready}, 1);
    endtask

    task automatic check_bus(input vec_t v);
        chk("abus", {20'd0, hba_abus}, {20'd0, v.addr});
        chk("rnw", {31'd0, hba_rnw}, {31'd0, v.rnw});
        chk("dbus", {24'd0, hba_dbus}, v.rnw ? 32'd0 : {24'd0, v.wdata});
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rnw   = v.rnw;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        wait_ready();
        rsp_q.push_back('{v.exp_rdata, v.exp_err});
        addr_q.push_back(v.addr);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("mreq_on", {31'd0, hba_mrequest}, 1);
        chk("ready_off", {31'd0, cmd_ready}, 0);
        repeat (v.gdly) begin
            @(posedge clk);
            #1;
            chk("mreq_hold", {31'd0, hba_mrequest}, 1);
        end
        hba_mgrant = 1'b1;
        @(posedge clk);
        #1;
        hba_mgrant = 1'b0;
        chk("sel_on", {31'd0, hba_select}, 1);
        chk("mreq_off", {31'd0, hba_mrequest}, 0);
        check_bus(v);
        if (v.adly >= 0) begin
            repeat (v.adly) begin
                @(posedge clk);
                #1;
                chk("sel_hold", {31'd0, hba_select}, 1);
                check_bus(v);
            end
            hba_xferack    = 1'b1;
            hba_dbus_slave = v.sdata;
            @(posedge clk);
            #1;
            hba_xferack    = 1'b0;
            hba_dbus_slave = '0;
            chk("sel_off", {31'd0, hba_select}, 0);
            chk("ready_back", {31'd0, cmd_ready}, 1);
        end else begin
            hba_dbus_slave = v.sdata;
            n = 1;
            while (hba_select && n < 100) begin
                @(posedge clk);
                #1;
                if (hba_select) n++;
            end
            hba_dbus_slave = '0;
            chk("sel_cycles", n, TO);
        end
        @(negedge clk);
        #1;
        chk("rsp_seen", rsp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1;
        int acc2;
        int rsp1;
        vecs[0] = '{1'b0, 12'h312, 8'hA5, 3, 2, 8'hEE, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 12'h105, 8'h99, 1, 0, 8'h3C, 8'h3C, 1'b0};
        vecs[2] = '{1'b1, 12'h2F0, 8'h00, 0, -1, 8'h77, 8'h3C, 1'b1};
        vecs[3] = '{1'b0, 12'h0FF, 8'h5A, 0, 0, 8'h11, 8'h3C, 1'b0};
        vecs[4] = '{1'b1, 12'h7AB, 8'h00, 2, 3, 8'hC3, 8'hC3, 1'b0};

        #2;
        hba_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, cmd_ready}, 0);
        chk("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_bus", {10'd0, hba_mrequest, hba_select, hba_abus,
                        hba_rnw, hba_dbus}, 0);
        hba_reset_n = 1'b1;
        #1;
        chk("rel_ready0", {31'd0, cmd_ready}, 0);
        @(posedge clk);
        #1;
        chk("rel_ready1", {31'd0, cmd_ready}, 1);

        for (int i = 0; i < 5; i++) run_txn(vecs[i]);

        // spurious grant in IDLE, spurious ack in REQ
        @(posedge clk);
        #1;
        hba_mgrant = 1'b1;
        @(posedge clk);
        #1;
        hba_mgrant = 1'b0;
        chk("spur_g_sel", {31'd0, hba_select}, 0);
        chk("spur_g_req", {31'd0, hba_mrequest}, 0);
        chk("spur_g_rdy", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b1;
        cmd_addr  = 12'h4CD;
        wait_ready();
        rsp_q.push_back('{8'h81, 1'b0});
        addr_q.push_back(12'h4CD);
        @(posedge clk);
        #1;
        cmd_valid      = 1'b0;
        hba_xferack    = 1'b1;
        hba_dbus_slave = 8'h55;
        @(posedge clk);
        #1;
        hba_xferack    = 1'b0;
        hba_dbus_slave = '0;
        chk("spur_a_sel", {31'd0, hba_select}, 0);
        chk("spur_a_req", {31'd0, hba_mrequest}, 1);
        chk("spur_a_rsp", {31'd0, rsp_valid}, 0);
        hba_mgrant = 1'b1;
        @(posedge clk);
        #1;
        hba_mgrant     = 1'b0;
        hba_xferack    = 1'b1;
        hba_dbus_slave = 8'h81;
        @(posedge clk);
        #1;
        hba_xferack    = 1'b0;
        hba_dbus_slave = '0;
        @(negedge clk);
        #1;
        chk("spur_rsp_seen", rsp_q.size(), 0);

        // reset asserted in XFER
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 12'h3A1;
        cmd_wdata = 8'h42;
        wait_ready();
        addr_q.push_back(12'h3A1);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        hba_mgrant = 1'b1;
        @(posedge clk);
        #1;
        hba_mgrant = 1'b0;
        chk("rx_sel_on", {31'd0, hba_select}, 1);
        @(negedge clk);
        #2;
        hba_reset_n = 1'b0;
        #1;
        chk("rx_sel", {31'd0, hba_select}, 0);
        chk("rx_abus", {20'd0, hba_abus}, 0);
        chk("rx_mreq", {31'd0, hba_mrequest}, 0);
        chk("rx_dbus", {24'd0, hba_dbus}, 0);
        @(posedge clk);
        #1;
        hba_reset_n = 1'b1;
        chk("rx_rdy0", {31'd0, cmd_ready}, 0);
        @(posedge clk);
        #1;
        chk("rx_rdy1", {31'd0, cmd_ready}, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rx_no_rsp", {31'd0, rsp_valid}, 0);
        end

        // two commands held back-to-back, responder answers at once
        auto_resp = 1'b1;
        cmd_valid = 1'b1;
        cmd_rnw   = 1'b0;
        cmd_addr  = 12'h210;
        cmd_wdata = 8'h0F;
        wait_ready();
        acc1 = cyc + 1;
        rsp_q.push_back('{8'h00, 1'b0});
        addr_q.push_back(12'h210);
        @(posedge clk);
        #1;
        cmd_addr  = 12'h321;
        cmd_wdata = 8'hF0;
        wait_ready();
        acc2 = cyc + 1;
        rsp_q.push_back('{8'h00, 1'b0});
        addr_q.push_back(12'h321);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp1 = last_rsp_cyc;
        chk("b2b_gap", acc2 - acc1, 3);
        chk("b2b_after_rsp", acc2, rsp1 + 1);
        repeat (6) @(posedge clk);
        #2;
        auto_resp   = 1'b0;
        hba_mgrant  = 1'b0;
        hba_xferack = 1'b0;
        chk("b2b_rsp_done", rsp_q.size(), 0);
        chk("b2b_addr_done", addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hba_master.md
# hba_master

Bus-master engine that lets a local peripheral issue single read/write transfers on the HBA bus. Accepts one command at a time on a valid/ready port and raises `hba_mrequest` to the HBA arbiter. After `hba_mgrant`, it drives address, direction and data with `hba_select` until the addressed slave returns `hba_xferack`, or until a timeout expires. It sits between a master peripheral's control logic and the shared HBA master-side bus. It is the requester end of the arbitration handshake.

## Interface
- `ADDR_WIDTH`, 12, HBA address width (4-bit slave id + 8-bit register).
- `DBUS_WIDTH`, 8, HBA data width.
- `TIMEOUT`, 255, cycles in XFER without `hba_xferack` before abort; range 1..65535.
- `hba_clk` in 1 — single clock; all logic rising-edge.
- `hba_reset_n` in 1 — asynchronous, active-low reset.
- `cmd_valid` in 1 — local command present.
- `cmd_ready` out 1 — engine idle; command accepted when `cmd_valid & cmd_ready`.
- `cmd_rnw` in 1 — 1 = read, 0 = write.
- `cmd_addr` in ADDR_WIDTH — target address.
- `cmd_wdata` in DBUS_WIDTH — write data; ignored for reads.
- `rsp_valid` out 1 — one-cycle completion pulse.
- `rsp_rdata` out DBUS_WIDTH — read data; held until the next completion.
- `rsp_err` out 1 — qualifies `rsp_valid`; 1 = timed out.
- `hba_mrequest` out 1 — bus request to the arbiter.
- `hba_mgrant` in 1 — grant pulse from the arbiter.
- `hba_select` out 1 — this master owns the bus.
- `hba_abus` out ADDR_WIDTH — address; 0 when not selected.
- `hba_rnw` out 1 — direction; 0 when not selected.
- `hba_dbus` out DBUS_WIDTH — write data; 0 when not selected or on reads. The bus is OR-combined, so zero is required.
- `hba_dbus_slave` in DBUS_WIDTH — OR-combined slave read data.
- `hba_xferack` in 1 — slave transfer acknowledge.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch addr/rnw/wdata and go to REQ.
  - REQ: `hba_mrequest`=1. When `hba_mgrant` is sampled high, go to XFER and clear the timeout counter.
  - XFER: `hba_select`=1, `hba_mrequest`=0. The bus outputs drive the latched values (`hba_dbus` = wdata only if write).
    - On `hba_xferack` sampled high: capture `hba_dbus_slave` into `rsp_rdata` if read, set `rsp_err`=0, pulse `rsp_valid`, go to IDLE.
    - Otherwise the counter increments. When it reaches TIMEOUT−1 with no ack, pulse `rsp_valid` with `rsp_err`=1, leave `rsp_rdata` unchanged, go to IDLE.
- `hba_mgrant` outside REQ is ignored (it belongs to another master or is stale).
- `hba_xferack` outside XFER is ignored.
- `cmd_valid` outside IDLE is not accepted; the caller holds it.
- Timeout counter width is `$clog2(TIMEOUT+1)` and never wraps; it saturates at the abort point.
- Every bus output is registered; no combinational path from any input to any `hba_*` output.

## Timing
- Reset (async assert, sync release) forces:
  - `cmd_ready`=0 while in reset, then 1 from the first clock after release.
  - All other outputs: 0, with `rsp_rdata`=0. State = IDLE.
- Reset asserted mid-transfer drops `hba_select`/`hba_mrequest` immediately. No response is produced.
- Accept at edge N → `hba_mrequest`=1 after edge N.
- `hba_mgrant` high at edge G → after edge G: `hba_select`=1, `hba_mrequest`=0, bus driven. Minimum accept-to-select latency is 2 cycles.
- `hba_xferack` high at edge A → after edge A: `hba_select`=0, bus zeroed, `rsp_valid`=1 for exactly one cycle, `cmd_ready`=1.
- Next command is accepted no earlier than edge A+1. Back-to-back best case is 3 cycles per transfer.
- Abort: the XFER entered at edge G ends after edge G+TIMEOUT.

## Structure
- Shared package `hba_pkg`: default ADDR/DBUS widths and the `hba_master_state_t` enum (IDLE, REQ, XFER).
- One natural sub-module, `hba_timeout_cnt`: clear/enable/expired saturating counter, parameterised by TIMEOUT.

## Test plan
- Write 0xA5 to 0x312, grant 3 cycles after request, ack 2 cycles after select → `hba_abus`=0x312, `hba_rnw`=0, `hba_dbus`=0xA5 while selected. Then `rsp_valid` pulse with `rsp_err`=0 and all bus outputs 0 after.
- Read 0x105, slave returns 0x3C with ack → `rsp_rdata`=0x3C, `hba_dbus`=0 throughout, `hba_rnw`=1 while selected.
- Spurious `hba_mgrant` in IDLE and spurious `hba_xferack` in REQ → no state change, `hba_select` stays 0.
- TIMEOUT=4, no ack → `hba_select` high exactly 4 cycles, then `rsp_valid`=1 with `rsp_err`=1, `rsp_rdata` unchanged.
- Deassert `hba_reset_n` while in XFER → `hba_select`, `hba_abus`, `hba_mrequest` go 0 before the next edge. After release, `cmd_ready`=1 and no `rsp_valid`.
- Two commands presented continuously → second accepted the cycle after the first's `rsp_valid`; addresses appear in order.
